// File: rtl/demux_rr_if.sv
// Handshake bundle between an upstream single-bit source and four downstream lanes.
interface demux_rr_if;
    localparam int unsigned N_LANES = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    logic               in_valid;
    logic               in_data;
    logic               in_ready;
    logic               mode;
    logic [SEL_W-1:0]   cfg_sel;
    logic [N_LANES-1:0] lane_en;
    logic [N_LANES-1:0] y;
    logic [N_LANES-1:0] y_valid;
    logic [N_LANES-1:0] y_ready;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic [CNT_W-1:0]   xfer_count;

    modport master (
        output in_valid, in_data, mode, cfg_sel, lane_en, y_ready,
        input  in_ready, y, y_valid, sel, busy, xfer_count
    );

    modport slave (
        input  in_valid, in_data, mode, cfg_sel, lane_en, y_ready,
        output in_ready, y, y_valid, sel, busy, xfer_count
    );
endinterface

// File: rtl/demux_rr_scheduler.sv
// Routes one accepted data bit to a single lane (fixed or round-robin) and holds it
// there until that lane's downstream accepts it.
module demux_rr_scheduler (
    input  logic        clk,
    input  logic        rst,
    demux_rr_if.slave   bus
);
    localparam int unsigned N_LANES = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   hold_sel_q, hold_sel_d;
    logic [N_LANES-1:0] y_q, y_d;
    logic [N_LANES-1:0] y_valid_q, y_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [SEL_W-1:0]   tgt_c;
    logic               avail_c;

    // Target lane; the descending scan lets the smallest offset from ptr win.
    always_comb begin : target
        logic [SEL_W-1:0] idx;
        tgt_c   = ptr_q;
        avail_c = 1'b0;
        idx     = ptr_q;
        if (!bus.mode) begin
            tgt_c   = bus.cfg_sel;
            avail_c = bus.lane_en[bus.cfg_sel];
        end else begin
            for (int i = N_LANES - 1; i >= 0; i--) begin
                idx = ptr_q + SEL_W'(i);
                if (bus.lane_en[idx]) begin
                    tgt_c   = idx;
                    avail_c = 1'b1;
                end
            end
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_sel_d = hold_sel_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && avail_c) begin
                    state_d    = HOLD;
                    hold_sel_d = tgt_c;
                    y_valid_d  = N_LANES'(1) << tgt_c;
                    y_d        = N_LANES'(bus.in_data) << tgt_c;
                end
            end
            HOLD: begin
                if (bus.y_ready[hold_sel_q]) begin
                    state_d   = IDLE;
                    y_d       = '0;
                    y_valid_d = '0;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (bus.mode) begin
                        ptr_d = hold_sel_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_sel_q <= '0;
            y_q        <= '0;
            y_valid_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_sel_q <= hold_sel_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    // in_ready and the IDLE view of sel must follow mode/lane_en within the same cycle.
    assign bus.in_ready   = (state_q == IDLE) && avail_c;
    assign bus.sel        = (state_q == HOLD) ? hold_sel_q : tgt_c;
    assign bus.busy       = (state_q == HOLD);
    assign bus.y          = y_q;
    assign bus.y_valid    = y_valid_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Scoreboard bench for demux_rr_scheduler: directed scenarios plus randomized traffic
// against a lane-level reference model.
module tb_demux_rr_scheduler;
    logic clk = 1'b0;
    logic rst;
    demux_rr_if bus ();

    demux_rr_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        bit data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state
    bit m_known = 0;
    bit m_hold  = 0;
    int m_lane  = 0;
    bit m_data  = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check visible outputs at negedge, advance the model.
    task automatic cycle(input bit r, input bit v, input bit d, input bit m,
                         input logic [1:0] cs, input logic [3:0] le, input logic [3:0] yr);
        int  t;
        bit  av;
        rst          = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.mode     = m;
        bus.cfg_sel  = cs;
        bus.lane_en  = le;
        bus.y_ready  = yr;
        t  = 0;
        av = 0;
        if (!m) begin
            t  = int'(cs);
            av = le[cs];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!av && le[(m_ptr + k) % 4]) begin
                    t  = (m_ptr + k) % 4;
                    av = 1;
                end
            end
        end
        @(negedge clk);
        if (m_known) begin
            check("in_ready", int'(bus.in_ready), int'(!m_hold && av));
            check("busy", int'(bus.busy), int'(m_hold));
            check("y_valid", int'(bus.y_valid), m_hold ? (1 << m_lane) : 0);
            check("xfer_count", int'(bus.xfer_count), m_cnt);
            if (m_hold)  check("sel_hold", int'(bus.sel), m_lane);
            else if (av) check("sel_idle", int'(bus.sel), t);
        end
        if (r) begin
            m_known = 1;
            m_hold  = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            exp_q.delete();
        end else if (m_known) begin
            if (!m_hold) begin
                if (v && av) begin
                    exp_t e;
                    e.lane = t;
                    e.data = d;
                    exp_q.push_back(e);
                    m_hold = 1;
                    m_lane = t;
                    m_data = d;
                end
            end else if (yr[m_lane]) begin
                m_hold = 0;
                m_cnt  = (m_cnt + 1) % 256;
                if (m) m_ptr = (m_lane + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream handshake must match the oldest accepted bit.
    initial begin
        forever begin
            @(negedge clk);
            if (m_known && !rst && ((bus.y_valid & bus.y_ready) != 4'b0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", int'(bus.y_valid), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("hs_lane_valid", int'(bus.y_valid), 1 << e.lane);
                    check("hs_lane_data", int'(bus.y), int'(e.data) << e.lane);
                    check("hs_sel", int'(bus.sel), e.lane);
                end
            end
        end
    end

    initial begin
        logic [3:0] bits;
        rst = 1'b1;
        bus.in_valid = 0; bus.in_data = 0; bus.mode = 0;
        bus.cfg_sel = 0; bus.lane_en = 0; bus.y_ready = 0;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 2'd0, 4'hf, 4'h0);
        cycle(0, 0, 0, 0, 2'd0, 4'hf, 4'h0);

        // Fixed lane 2
        cycle(0, 1, 1, 0, 2'd2, 4'hf, 4'h0);
        cycle(0, 0, 0, 0, 2'd2, 4'hf, 4'b0100);
        cycle(0, 0, 0, 0, 2'd2, 4'hf, 4'h0);

        // Round-robin over all lanes with immediate accept
        cycle(1, 0, 0, 1, 2'd0, 4'hf, 4'h0);
        bits = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, bits[i], 1, 2'd0, 4'hf, 4'h0);
            cycle(0, 0, 0, 1, 2'd0, 4'hf, 4'hf);
        end
        cycle(0, 0, 0, 1, 2'd0, 4'hf, 4'h0);

        // Lane skipping with mask 1010
        cycle(1, 0, 0, 1, 2'd0, 4'b1010, 4'h0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 1, 2'd0, 4'b1010, 4'h0);
            cycle(0, 0, 0, 1, 2'd0, 4'b1010, 4'hf);
        end

        // Backpressure on lane 1, other lanes' ready ignored, inputs wiggle in HOLD
        cycle(1, 0, 0, 0, 2'd1, 4'hf, 4'h0);
        cycle(0, 1, 1, 0, 2'd1, 4'hf, 4'h0);
        for (int i = 0; i < 5; i++)
            cycle(0, 1, i[0], i[1], 2'(i), 4'hf, 4'b1101);
        cycle(0, 0, 0, 0, 2'd1, 4'hf, 4'b0010);
        cycle(0, 0, 0, 0, 2'd1, 4'hf, 4'h0);

        // No lane available
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 2'd0, 4'b0000, 4'hf);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 2'd2, 4'b1011, 4'hf);

        // Reset while holding with ready asserted, then counter wrap
        cycle(0, 1, 1, 1, 2'd0, 4'b0100, 4'h0);
        cycle(1, 0, 0, 1, 2'd0, 4'hf, 4'hf);
        cycle(0, 0, 0, 1, 2'd0, 4'hf, 4'h0);
        for (int i = 0; i < 256; i++) begin
            cycle(0, 1, i[0], 0, 2'd3, 4'hf, 4'h0);
            cycle(0, 0, 0, 0, 2'd3, 4'hf, 4'b1000);
        end
        cycle(0, 0, 0, 0, 2'd3, 4'hf, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 3) != 0),
                  bit'($urandom), bit'($urandom), 2'($urandom), 4'($urandom),
                  4'($urandom));
        end

        // Drain: any held bit must be delivered within a few cycles
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 2'd0, 4'hf, 4'hf);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_rr_scheduler.md
DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 SHALL provide the following ports; clock and reset first; name, direction, width, meaning:
REQ-002 SHALL provide clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL provide in_valid, input, 1, the upstream source offers in_data.
REQ-005 SHALL provide in_data, input, 1, the serial data bit to be routed to one lane.
REQ-006 SHALL provide in_ready, output, 1, the block accepts in_data this cycle.
REQ-007 SHALL provide mode, input, 1, 0 = fixed lane (cfg_sel), 1 = round-robin.
REQ-008 SHALL provide cfg_sel, input, 2, the target lane in fixed mode.
REQ-009 SHALL provide lane_en, input, 4, the per-lane enable mask; disabled lanes are never targeted.
REQ-010 SHALL provide y, output, 4, the per-lane data; only the active lane may be nonzero.
REQ-011 SHALL provide y_valid, output, 4, one-hot or zero; marks the lane holding data.
REQ-012 SHALL provide y_ready, input, 4, the per-lane downstream accept.
REQ-013 SHALL provide sel, output, 2, the lane currently held (HOLD) or next target (IDLE).
REQ-014 SHALL provide busy, output, 1, high in HOLD.
REQ-015 SHALL provide xfer_count, output, 8, the count of completed lane handshakes.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no data held) and HOLD (one bit held on one lane).
REQ-017 SHALL define the target lane in fixed mode as cfg_sel, and as available only if lane_en[cfg_sel]=1.
REQ-018 SHALL define the target lane in round-robin mode as the first lane with lane_en=1, searching ptr, ptr+1, ... with wrap 3->0; none is available if lane_en=0000.
REQ-019 SHALL assert in_ready in IDLE only when a target lane is available; in_ready SHALL be 0 in HOLD.
REQ-020 SHALL, on IDLE with in_valid=1 and in_ready=1: next cycle y[target]=in_data, other y bits 0, y_valid one-hot at target, sel=target, state HOLD (accept-to-valid latency 1 cycle).
REQ-021 SHALL hold y, y_valid and sel stable in HOLD regardless of in_data, mode, cfg_sel or lane_en changes.
REQ-022 SHALL complete a handshake in HOLD when y_ready[sel]=1; next cycle: y=0, y_valid=0, state IDLE, xfer_count+1 (wraps 255->0).
REQ-023 SHALL, on a round-robin handshake, set ptr=sel+1 mod 4; in fixed mode ptr is unchanged.
REQ-024 SHALL ignore y_ready bits of non-selected lanes.
REQ-025 SHALL limit maximum throughput to one bit per 2 cycles (accept, then handshake).
REQ-026 SHALL, if mode changes while in IDLE, apply the new target rule in the same cycle (combinational target).
REQ-027 SHALL, when lane_en=0000 in round-robin mode, keep in_ready=0 and leave ptr unchanged.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, ptr=0, y=0000, y_valid=0000, xfer_count=0, busy=0; sel SHALL show the IDLE target.
REQ-029 SHALL have rst take priority over any handshake in the same cycle; held data is discarded and not counted.

Verification
REQ-030 SHALL be covered by a fixed-mode test: mode=0, cfg_sel=2, lane_en=1111, in_data=1 accepted -> next cycle y=0100, y_valid=0100; y_ready=0100 -> y_valid=0000, xfer_count=1.
REQ-031 SHALL be covered by a round-robin test: lane_en=1111, four bits 1,0,1,1 with immediate y_ready -> lanes 0,1,2,3 in order, xfer_count=4, ptr back to 0.
REQ-032 SHALL be covered by a lane-skip test: mode=1, lane_en=1010 from reset -> transfers go to lanes 1,3,1,3.
REQ-033 SHALL be covered by a backpressure test: HOLD on lane 1 with y_ready=1101 for 5 cycles -> y_valid stays 0010, in_ready=0, count unchanged; y_ready=0010 completes it.
REQ-034 SHALL be covered by a no-lane test: mode=1, lane_en=0000, in_valid=1 -> in_ready=0 indefinitely; fixed mode with lane_en[cfg_sel]=0 -> in_ready=0.
REQ-035 SHALL be covered by a reset-mid-operation test: rst in HOLD with y_ready[sel]=1 -> next cycle y_valid=0000, xfer_count=0, ptr=0; 256 handshakes -> xfer_count wraps to 0.
